stage12_fetch: RTL and testbench
================================

// Module: stage12_fetch
// PURPOSE
//  Parametrised fetch/decode front end of the CPU pipeline; successor to the fixed 4-byte stage12.
//  Reads INSTR_BYTES consecutive bytes at pc from the byte-wide synchronous RAM.
//  Decodes the opcode, updates pc, and hands one token per instruction to stage 3
//  over a valid/ready handshake. Replaces the event-driven stage12_clk/stage12_ready scheme.
//  Also flags illegal opcodes.
// PARAMETERS
//  ADDR_W       16  width of pc, RAM address and stage-3 read address
//  INSTR_BYTES  4   bytes per instruction (>=2); byte0 = opcode, byte1 = operand
//  RAM_LAT      2   posedges from address applied to data captured (>=2; RAM registers data_out)
//  RESET_PC     0   pc value after reset
// PORTS
//  ram_clk            in   1              single clock for block and RAM
//  rst                in   1              asynchronous, active-low reset
//  ram_address        out  ADDR_W         RAM byte address = pc+k (mod 2^ADDR_W)
//  ram_write_enable   out  1              always 0 (fetch never writes)
//  ram_data_out       in   8              RAM registered read data
//  s3_valid           out  1              token for stage 3 is present
//  s3_ready           in   1              stage 3 accepts the token
//  s3_opcode          out  8              byte0 of the instruction
//  s3_pc              out  ADDR_W         address of the instruction the token describes
//  stage3_read        out  1              1 = token is READRAM8
//  stage3_read_address out ADDR_W         byte1 zero-extended to ADDR_W (valid when stage3_read)
//  instruction        out  8*INSTR_BYTES  raw bytes; byte k at [8k+7:8k]
//  pc                 out  ADDR_W         current program counter
//  illegal            out  1              sticky: an undefined opcode was decoded
// BEHAVIOUR
//  Reset (rst=0, async): state=FETCH, k=0, w=0, pc=RESET_PC.
//   All other outputs 0; ram_address=RESET_PC; instruction=0.
//  FETCH: ram_address=pc+k (combinational from registered pc, k).
//   w counts edges 0..RAM_LAT-1.
//   On the edge where w==RAM_LAT-1: instruction byte k <= ram_data_out; w<=0; k<=k+1.
//   After byte INSTR_BYTES-1 is captured -> DECODE.
//   Cost: INSTR_BYTES*RAM_LAT edges.
//  DECODE (one edge): s3_pc<=pc; s3_opcode<=byte0; stage3_read<=0; s3_valid<=1 -> OFFER.
//   Opcode 1 READRAM8: stage3_read<=1; stage3_read_address<={0,byte1}; pc<=pc+INSTR_BYTES.
//   Opcode 2 JUMPMINUS: pc<=pc-byte1*INSTR_BYTES, modulo 2^ADDR_W.
//    Operand 0 re-executes the same pc.
//   Opcode 0 NOP: pc<=pc+INSTR_BYTES.
//   Any other opcode: illegal<=1 (cleared only by reset); pc<=pc+INSTR_BYTES; token still issued.
//   All pc arithmetic wraps modulo 2^ADDR_W, including pc+k during FETCH.
//  OFFER: s3_valid=1; all s3_*/stage3_* outputs held stable.
//   On an edge with s3_ready=1: s3_valid<=0; k<=0; w<=0 -> FETCH at the new pc.
//   No overlap: the next fetch starts only after acceptance.
//   s3_ready is ignored outside OFFER.
//  Latency: first s3_valid rises on edge INSTR_BYTES*RAM_LAT+1 after reset release (9 with defaults).
//   Each accepted token adds the same latency for the next token.
//   Fastest throughput: one instruction per INSTR_BYTES*RAM_LAT+2 edges.
//  Reset mid-fetch or mid-OFFER: immediate abort, token dropped, restart from RESET_PC.
// TESTING
//  1 Reset value: rst=0 -> s3_valid=0, stage3_read=0, illegal=0, pc=0, ram_write_enable=0.
//  2 READRAM8: mem[0..3]=01 20 00 00, s3_ready=1.
//    -> s3_valid on edge 9; stage3_read=1, stage3_read_address=0x0020, s3_pc=0; pc=4.
//  3 Backpressure: as test 2 with s3_ready=0 for 5 cycles.
//    -> token stable throughout; no RAM address change; accepted on the first edge with s3_ready=1.
//  4 Jump: mem[4..7]=02 01 00 00 after test 2 -> token opcode 2, stage3_read=0, pc back to 0.
//    Loop repeats READRAM8 indefinitely.
//  5 Wrap: mem[0..3]=02 01 00 00 -> pc=0xFFFC.
//    Fetch addresses FFFC..FFFF.
//    INSTR_BYTES=2, RAM_LAT=3 run: mem[0..1]=01 05 -> s3_valid on edge 7, stage3_read_address=5, pc=2.
//  6 Illegal/reset: mem[0..3]=7F 00 00 00 -> illegal=1, pc=4.
//    Assert rst during the next fetch -> illegal=0, pc=0, s3_valid=0 asynchronously.

Source files
------------

// File: rtl/stage12_fetch.sv
// Parametrised fetch/decode front end: byte-serial instruction fetch from a
// registered RAM, opcode decode and a valid/ready token to stage 3.
module stage12_fetch #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_BYTES = 4,
  parameter int RAM_LAT     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     ram_clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        ram_address,
  output logic                     ram_write_enable,
  input  logic [7:0]               ram_data_out,
  output logic                     s3_valid,
  input  logic                     s3_ready,
  output logic [7:0]               s3_opcode,
  output logic [ADDR_W-1:0]        s3_pc,
  output logic                     stage3_read,
  output logic [ADDR_W-1:0]        stage3_read_address,
  output logic [8*INSTR_BYTES-1:0] instruction,
  output logic [ADDR_W-1:0]        pc,
  output logic                     illegal
);

  localparam int KW = $clog2(INSTR_BYTES);
  localparam int WW = $clog2(RAM_LAT);
  localparam logic [KW-1:0] K_LAST = KW'(INSTR_BYTES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RAM_LAT - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    OFFER  = 2'd2
  } state_t;

  state_t state, state_n;
  logic [KW-1:0] k;
  logic [WW-1:0] w;

  logic [7:0] op;
  logic [7:0] opnd;
  logic op_read, op_jump, op_nop;
  logic [ADDR_W-1:0] pc_dec;
  logic byte_done;

  assign op   = instruction[7:0];
  assign opnd = instruction[15:8];
  assign byte_done = (w == W_LAST);

  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:   if (byte_done && k == K_LAST) state_n = DECODE;
      DECODE:  state_n = OFFER;
      OFFER:   if (s3_ready) state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    ram_address      = pc + ADDR_W'(k);
    ram_write_enable = 1'b0;
    op_read = (op == 8'd1);
    op_jump = (op == 8'd2);
    op_nop  = (op == 8'd0);
    pc_dec  = pc + STEP;
    unique case (1'b1)
      op_jump: pc_dec = pc - ADDR_W'(opnd) * STEP;
      default: pc_dec = pc + STEP;
    endcase
  end

  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      k                   <= '0;
      w                   <= '0;
      pc                  <= RESET_PC;
      instruction         <= '0;
      s3_valid            <= 1'b0;
      s3_opcode           <= '0;
      s3_pc               <= '0;
      stage3_read         <= 1'b0;
      stage3_read_address <= '0;
      illegal             <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (byte_done) begin
            instruction[int'(k)*8 +: 8] <= ram_data_out;
            w <= '0;
            k <= (k == K_LAST) ? '0 : k + KW'(1);
          end else begin
            w <= w + WW'(1);
          end
        end
        DECODE: begin
          s3_pc       <= pc;
          s3_opcode   <= op;
          stage3_read <= op_read;
          s3_valid    <= 1'b1;
          pc          <= pc_dec;
          if (op_read) stage3_read_address <= ADDR_W'(opnd);
          if (!(op_read || op_jump || op_nop)) illegal <= 1'b1;
        end
        OFFER: begin
          if (s3_ready) begin
            s3_valid <= 1'b0;
            k        <= '0;
            w        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage12_fetch.sv
// Directed bench for stage12_fetch: default build plus a 2-byte,
// 3-cycle-latency build, each fed by a registered byte RAM model.
module tb_stage12_fetch;

  logic        ram_clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst1 = 1'b0;
  logic [15:0] ram_address, ram_address1;
  logic        ram_write_enable, ram_write_enable1;
  logic [7:0]  ram_data_out = 8'h00;
  logic [7:0]  ram_data_out1 = 8'h00;
  logic        s3_valid, s3_valid1;
  logic        s3_ready = 1'b0;
  logic        s3_ready1 = 1'b0;
  logic [7:0]  s3_opcode, s3_opcode1;
  logic [15:0] s3_pc, s3_pc1;
  logic        stage3_read, stage3_read1;
  logic [15:0] stage3_read_address, stage3_read_address1;
  logic [31:0] instruction;
  logic [15:0] instruction1;
  logic [15:0] pc, pc1;
  logic        illegal, illegal1;

  logic [7:0] mem [0:65535];
  logic [7:0] mem1 [0:255];

  int vectors = 0;
  int miscompares = 0;

  always #5 ram_clk = ~ram_clk;

  always @(posedge ram_clk) begin
    ram_data_out  <= mem[ram_address];
    ram_data_out1 <= mem1[ram_address1[7:0]];
  end

  stage12_fetch u0 (
    .ram_clk(ram_clk), .rst(rst),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out),
    .s3_valid(s3_valid), .s3_ready(s3_ready),
    .s3_opcode(s3_opcode), .s3_pc(s3_pc),
    .stage3_read(stage3_read),
    .stage3_read_address(stage3_read_address),
    .instruction(instruction), .pc(pc), .illegal(illegal)
  );

  stage12_fetch #(.INSTR_BYTES(2), .RAM_LAT(3)) u1 (
    .ram_clk(ram_clk), .rst(rst1),
    .ram_address(ram_address1), .ram_write_enable(ram_write_enable1),
    .ram_data_out(ram_data_out1),
    .s3_valid(s3_valid1), .s3_ready(s3_ready1),
    .s3_opcode(s3_opcode1), .s3_pc(s3_pc1),
    .stage3_read(stage3_read1),
    .stage3_read_address(stage3_read_address1),
    .instruction(instruction1), .pc(pc1), .illegal(illegal1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (s3_valid !== 1'b1 && n < 40) begin
      @(negedge ram_clk);
      n++;
    end
    check(tag, 32'(s3_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h20;
    mem[4] = 8'h02; mem[5] = 8'h01;
    mem1[0] = 8'h01; mem1[1] = 8'h05;

    // reset state
    repeat (2) @(negedge ram_clk);
    check("rst_valid", 32'(s3_valid), 32'd0);
    check("rst_read", 32'(stage3_read), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_we", 32'(ram_write_enable), 32'd0);
    check("rst_addr", 32'(ram_address), 32'h0);
    check("rst_instr", instruction, 32'h0);

    // READRAM8 with exact latency, then backpressure
    rst = 1'b1;
    repeat (8) @(posedge ram_clk);
    @(negedge ram_clk);
    check("rd_valid_e8", 32'(s3_valid), 32'd0);
    @(posedge ram_clk);
    @(negedge ram_clk);
    check("rd_valid_e9", 32'(s3_valid), 32'd1);
    check("rd_read", 32'(stage3_read), 32'd1);
    check("rd_raddr", 32'(stage3_read_address), 32'h0020);
    check("rd_s3pc", 32'(s3_pc), 32'h0);
    check("rd_pc", 32'(pc), 32'h4);
    check("rd_instr", instruction, 32'h0000_2001);
    for (int i = 0; i < 5; i++) begin
      @(negedge ram_clk);
      check("bp_valid", 32'(s3_valid), 32'd1);
      check("bp_op", 32'(s3_opcode), 32'h01);
      check("bp_raddr", 32'(stage3_read_address), 32'h0020);
      check("bp_addr", 32'(ram_address), 32'h4);
    end
    s3_ready = 1'b1;
    @(negedge ram_clk);
    check("bp_accept", 32'(s3_valid), 32'd0);

    // jump back and loop
    wait_valid("jmp_wait");
    check("jmp_op", 32'(s3_opcode), 32'h02);
    check("jmp_read", 32'(stage3_read), 32'd0);
    check("jmp_s3pc", 32'(s3_pc), 32'h4);
    check("jmp_pc", 32'(pc), 32'h0);
    @(negedge ram_clk);
    wait_valid("loop_wait");
    check("loop_op", 32'(s3_opcode), 32'h01);
    check("loop_s3pc", 32'(s3_pc), 32'h0);
    check("loop_pc", 32'(pc), 32'h4);

    // wrap below zero
    rst = 1'b0;
    mem[0] = 8'h02; mem[1] = 8'h01;
    @(negedge ram_clk);
    rst = 1'b1;
    wait_valid("wrap_wait");
    check("wrap_op", 32'(s3_opcode), 32'h02);
    check("wrap_pc", 32'(pc), 32'hFFFC);
    @(negedge ram_clk);
    check("wrap_a0", 32'(ram_address), 32'hFFFC);
    repeat (2) @(negedge ram_clk);
    check("wrap_a1", 32'(ram_address), 32'hFFFD);
    repeat (2) @(negedge ram_clk);
    check("wrap_a2", 32'(ram_address), 32'hFFFE);
    repeat (2) @(negedge ram_clk);
    check("wrap_a3", 32'(ram_address), 32'hFFFF);
    wait_valid("wrap_nop_wait");
    check("wrap_nop_op", 32'(s3_opcode), 32'h00);
    check("wrap_nop_s3pc", 32'(s3_pc), 32'hFFFC);
    check("wrap_nop_pc", 32'(pc), 32'h0);

    // illegal opcode, then async reset mid-fetch
    rst = 1'b0;
    mem[0] = 8'h7F; mem[1] = 8'h00;
    @(negedge ram_clk);
    rst = 1'b1;
    wait_valid("ill_wait");
    check("ill_op", 32'(s3_opcode), 32'h7F);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_pc", 32'(pc), 32'h4);
    @(negedge ram_clk);
    check("ill_sticky", 32'(illegal), 32'd1);
    repeat (3) @(negedge ram_clk);
    rst = 1'b0;
    #1;
    check("arst_illegal", 32'(illegal), 32'd0);
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_valid", 32'(s3_valid), 32'd0);
    check("arst_addr", 32'(ram_address), 32'h0);

    // 2-byte, 3-cycle latency build
    @(negedge ram_clk);
    rst1 = 1'b1;
    repeat (6) @(posedge ram_clk);
    @(negedge ram_clk);
    check("p_valid_e6", 32'(s3_valid1), 32'd0);
    @(posedge ram_clk);
    @(negedge ram_clk);
    check("p_valid_e7", 32'(s3_valid1), 32'd1);
    check("p_read", 32'(stage3_read1), 32'd1);
    check("p_raddr", 32'(stage3_read_address1), 32'h5);
    check("p_pc", 32'(pc1), 32'h2);
    check("p_instr", 32'(instruction1), 32'h0501);
    check("p_we", 32'(ram_write_enable1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
